// File: rtl/flight_phase_qualifier.sv
// Flight-phase qualifier: debounces the raw avionics phase code, enforces the
// legal phase sequence and reports faults to the cabin controller.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no phase held; waiting for the first valid raw sample
// QUAL   | candidate phase being counted toward acceptance
// STABLE | flight_phase accepted; watching for change or signal loss
// FAULT  | illegal transition, invalid code or loss; waits for fault_clear
module flight_phase_qualifier #(
    parameter int STABLE_CYCLES = 4,
    parameter int LOSS_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       raw_valid,
    input  logic [2:0] raw_phase,
    input  logic       fault_clear,
    output logic [2:0] flight_phase,
    output logic       phase_stable,
    output logic       phase_changed,
    output logic       fault_detected,
    output logic [1:0] fault_code
);

    localparam int QW = $clog2(STABLE_CYCLES + 1);
    localparam int LW = $clog2(LOSS_CYCLES + 1);

    localparam logic [QW-1:0] Q_ZERO = '0;
    localparam logic [QW-1:0] Q_ONE  = QW'(1);
    localparam logic [QW-1:0] Q_TC   = QW'(STABLE_CYCLES - 1);
    localparam logic [LW-1:0] L_ZERO = '0;
    localparam logic [LW-1:0] L_ONE  = LW'(1);
    localparam logic [LW-1:0] L_TC   = LW'(LOSS_CYCLES - 1);
    localparam logic [LW-1:0] L_MAX  = LW'(LOSS_CYCLES);

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_INVALID = 2'b10;
    localparam logic [1:0] FC_LOSS    = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUAL   = 2'd1,
        STABLE = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t          state;
    logic [2:0]      cand;
    logic [QW-1:0]   qual_cnt;
    logic [LW-1:0]   loss_cnt;
    logic            have_phase;

    // Allowed phase moves, encoded as {from, to} in octal.
    function automatic logic is_legal(input logic [2:0] from_ph, input logic [2:0] to_ph);
        case ({from_ph, to_ph})
            6'o01, 6'o12, 6'o23, 6'o34, 6'o45, 6'o56,
            6'o61, 6'o10, 6'o21, 6'o53, 6'o63, 6'o35: is_legal = 1'b1;
            default:                                   is_legal = 1'b0;
        endcase
    endfunction

    // Qualification FSM; every output is registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cand           <= 3'd0;
            qual_cnt       <= Q_ZERO;
            loss_cnt       <= L_ZERO;
            have_phase     <= 1'b0;
            flight_phase   <= 3'd0;
            phase_stable   <= 1'b0;
            phase_changed  <= 1'b0;
            fault_detected <= 1'b0;
            fault_code     <= FC_NONE;
        end else if (!en) begin
            phase_changed <= 1'b0;
        end else begin
            phase_changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (raw_valid) begin
                        cand     <= raw_phase;
                        qual_cnt <= Q_ONE;
                        state    <= QUAL;
                    end
                end

                STABLE: begin
                    if (raw_valid) begin
                        if (raw_phase != flight_phase) begin
                            cand         <= raw_phase;
                            qual_cnt     <= Q_ONE;
                            state        <= QUAL;
                            phase_stable <= 1'b0;
                        end else begin
                            loss_cnt <= L_ZERO;
                        end
                    end else if (loss_cnt >= L_TC) begin
                        loss_cnt       <= L_MAX;
                        state          <= FAULT;
                        phase_stable   <= 1'b0;
                        fault_detected <= 1'b1;
                        fault_code     <= FC_LOSS;
                    end else begin
                        loss_cnt <= loss_cnt + L_ONE;
                    end
                end

                QUAL: begin
                    if (!raw_valid) begin
                        qual_cnt <= Q_ZERO;
                        if (have_phase) begin
                            state        <= STABLE;
                            phase_stable <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (have_phase && (raw_phase == flight_phase)) begin
                        // short excursion away from the held phase: drop it silently
                        qual_cnt     <= Q_ZERO;
                        state        <= STABLE;
                        phase_stable <= 1'b1;
                    end else if (raw_phase != cand) begin
                        cand     <= raw_phase;
                        qual_cnt <= Q_ONE;
                    end else if (qual_cnt >= Q_TC) begin
                        qual_cnt <= Q_ZERO;
                        if (cand == 3'd7) begin
                            state          <= FAULT;
                            fault_detected <= 1'b1;
                            fault_code     <= FC_INVALID;
                        end else if (have_phase && !is_legal(flight_phase, cand)) begin
                            state          <= FAULT;
                            fault_detected <= 1'b1;
                            fault_code     <= FC_ILLEGAL;
                        end else begin
                            flight_phase  <= cand;
                            have_phase    <= 1'b1;
                            state         <= STABLE;
                            phase_stable  <= 1'b1;
                            phase_changed <= 1'b1;
                            loss_cnt      <= L_ZERO;
                        end
                    end else begin
                        qual_cnt <= qual_cnt + Q_ONE;
                    end
                end

                FAULT: begin
                    if (fault_clear) begin
                        state          <= IDLE;
                        have_phase     <= 1'b0;
                        loss_cnt       <= L_ZERO;
                        fault_detected <= 1'b0;
                        fault_code     <= FC_NONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flight_phase_qualifier.sv
// Scenario bench for flight_phase_qualifier (STABLE_CYCLES=4, LOSS_CYCLES=8).
// Each row drives one cycle of inputs and queues the outputs expected after
// the following rising edge: {flight_phase, stable, changed, fault, code}.
module tb_flight_phase_qualifier;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b1;
    logic       raw_valid = 1'b0;
    logic [2:0] raw_phase = 3'd0;
    logic       fault_clear = 1'b0;
    logic [2:0] flight_phase;
    logic       phase_stable;
    logic       phase_changed;
    logic       fault_detected;
    logic [1:0] fault_code;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb_q[$];

    typedef struct packed {
        logic       v;
        logic [2:0] p;
        logic       clr;
        logic       e;
        logic [7:0] exp;
    } row_t;

    flight_phase_qualifier #(.STABLE_CYCLES(4), .LOSS_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .raw_valid(raw_valid),
        .raw_phase(raw_phase), .fault_clear(fault_clear),
        .flight_phase(flight_phase), .phase_stable(phase_stable),
        .phase_changed(phase_changed), .fault_detected(fault_detected),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run time exceeded, compared %0d", n_cmp);
        $fatal(1);
    end

    function automatic logic [7:0] ex(input logic [2:0] fp, input logic st, input logic ch,
                                      input logic fd, input logic [1:0] fc);
        return {fp, st, ch, fd, fc};
    endfunction

    function automatic logic [7:0] obs();
        return {flight_phase, phase_stable, phase_changed, fault_detected, fault_code};
    endfunction

    function automatic row_t r(input logic v, input logic [2:0] p, input logic clr,
                               input logic e, input logic [7:0] exp);
        return '{v: v, p: p, clr: clr, e: e, exp: exp};
    endfunction

    task automatic drive(input logic v, input logic [2:0] p, input logic clr, input logic e);
        raw_valid = v; raw_phase = p; fault_clear = clr; en = e;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        raw_valid = 1'b0; fault_clear = 1'b0; en = 1'b1;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // first acquisition after IDLE takes any code without a transition check
    task automatic acquire(input logic [2:0] p);
        for (int i = 0; i < 4; i++) drive(1'b1, p, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [7:0] got, exp_v;
        raw_valid = 1'b0; fault_clear = 1'b0; en = 1'b1;
        @(negedge clk); reset_n = 1'b0; #1;
        n_cmp++;
        if (obs() !== 8'h00) begin
            n_err++; $display("FAIL reset_state: got %b expected %b", obs(), 8'h00);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rows.push_back(r(1, 3'd0, 0, 1, ex(0, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd0, 0, 1, ex(0, 1, 1, 0, 0)));
        rows.push_back(r(1, 3'd0, 0, 1, ex(0, 1, 0, 0, 0)));
        // phase change 0 -> 1
        for (int i = 0; i < 3; i++) rows.push_back(r(1, 3'd1, 0, 1, ex(0, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd1, 0, 1, ex(1, 1, 1, 0, 0)));
        rows.push_back(r(1, 3'd1, 0, 1, ex(1, 1, 0, 0, 0)));
        // fault_clear outside FAULT has no effect
        rows.push_back(r(1, 3'd1, 1, 1, ex(1, 1, 0, 0, 0)));
        foreach (rows[i]) begin
            raw_valid = rows[i].v; raw_phase = rows[i].p; fault_clear = rows[i].clr; en = rows[i].e;
            sb_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front(); got = obs(); n_cmp++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL acquire[%0d]: got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        row_t rows[$];
        logic [7:0] got, exp_v;
        do_reset(); acquire(3'd3);
        rows.push_back(r(1, 3'd4, 0, 1, ex(3, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd4, 0, 1, ex(3, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd3, 0, 1, ex(3, 1, 0, 0, 0)));
        rows.push_back(r(1, 3'd3, 0, 1, ex(3, 1, 0, 0, 0)));
        // abort by raw_valid low returns to STABLE
        rows.push_back(r(1, 3'd4, 0, 1, ex(3, 0, 0, 0, 0)));
        rows.push_back(r(0, 3'd4, 0, 1, ex(3, 1, 0, 0, 0)));
        // candidate restart: 5,5,4 then 4 for a full count
        rows.push_back(r(1, 3'd5, 0, 1, ex(3, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd5, 0, 1, ex(3, 0, 0, 0, 0)));
        for (int i = 0; i < 3; i++) rows.push_back(r(1, 3'd4, 0, 1, ex(3, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd4, 0, 1, ex(4, 1, 1, 0, 0)));
        foreach (rows[i]) begin
            raw_valid = rows[i].v; raw_phase = rows[i].p; fault_clear = rows[i].clr; en = rows[i].e;
            sb_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front(); got = obs(); n_cmp++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL glitch[%0d]: got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_illegal_fault();
        row_t rows[$];
        logic [7:0] got, exp_v;
        do_reset(); acquire(3'd0);
        for (int i = 0; i < 3; i++) rows.push_back(r(1, 3'd4, 0, 1, ex(0, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd4, 0, 1, ex(0, 0, 0, 1, 2'b01)));
        rows.push_back(r(1, 3'd4, 0, 1, ex(0, 0, 0, 1, 2'b01)));
        rows.push_back(r(1, 3'd0, 1, 1, ex(0, 0, 0, 0, 0)));
        for (int i = 0; i < 3; i++) rows.push_back(r(1, 3'd0, 0, 1, ex(0, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd0, 0, 1, ex(0, 1, 1, 0, 0)));
        foreach (rows[i]) begin
            raw_valid = rows[i].v; raw_phase = rows[i].p; fault_clear = rows[i].clr; en = rows[i].e;
            sb_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front(); got = obs(); n_cmp++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL illegal[%0d]: got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_illegal_pairs();
        logic [2:0] from_l[5] = '{3'd3, 3'd6, 3'd0, 3'd4, 3'd1};
        logic [2:0] to_l[5]   = '{3'd2, 3'd5, 3'd2, 3'd3, 3'd3};
        logic [7:0] got, exp_v;
        for (int k = 0; k < 5; k++) begin
            do_reset(); acquire(from_l[k]);
            for (int i = 0; i < 4; i++) begin
                raw_valid = 1'b1; raw_phase = to_l[k]; fault_clear = 1'b0; en = 1'b1;
                sb_q.push_back((i == 3) ? ex(from_l[k], 0, 0, 1, 2'b01) : ex(from_l[k], 0, 0, 0, 0));
                @(posedge clk); #1;
                exp_v = sb_q.pop_front(); got = obs(); n_cmp++;
                if (got !== exp_v) begin
                    n_err++;
                    $display("FAIL pair_%0d_%0d[%0d]: got %b expected %b", from_l[k], to_l[k], i, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq[17] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd5, 3'd3, 3'd4,
                               3'd5, 3'd6, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd0};
        logic [7:0] got, exp_v;
        do_reset(); acquire(seq[0]);
        for (int k = 1; k < 17; k++) begin
            for (int i = 0; i < 4; i++) begin
                raw_valid = 1'b1; raw_phase = seq[k]; fault_clear = 1'b0; en = 1'b1;
                sb_q.push_back((i == 3) ? ex(seq[k], 1, 1, 0, 0) : ex(seq[k-1], 0, 0, 0, 0));
                @(posedge clk); #1;
                exp_v = sb_q.pop_front(); got = obs(); n_cmp++;
                if (got !== exp_v) begin
                    n_err++;
                    $display("FAIL seq_%0d_to_%0d[%0d]: got %b expected %b", seq[k-1], seq[k], i, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_invalid_and_loss();
        row_t rows[$];
        logic [7:0] got, exp_v;
        do_reset(); acquire(3'd4);
        for (int i = 0; i < 3; i++) rows.push_back(r(1, 3'd7, 0, 1, ex(4, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd7, 0, 1, ex(4, 0, 0, 1, 2'b10)));
        rows.push_back(r(0, 3'd0, 1, 1, ex(4, 0, 0, 0, 0)));
        // reacquire 2 from IDLE, then 7 missing cycles do not fault
        for (int i = 0; i < 3; i++) rows.push_back(r(1, 3'd2, 0, 1, ex(4, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd2, 0, 1, ex(2, 1, 1, 0, 0)));
        for (int i = 0; i < 7; i++) rows.push_back(r(0, 3'd2, 0, 1, ex(2, 1, 0, 0, 0)));
        rows.push_back(r(1, 3'd2, 0, 1, ex(2, 1, 0, 0, 0)));
        for (int i = 0; i < 7; i++) rows.push_back(r(0, 3'd2, 0, 1, ex(2, 1, 0, 0, 0)));
        rows.push_back(r(0, 3'd2, 0, 1, ex(2, 0, 0, 1, 2'b11)));
        rows.push_back(r(1, 3'd3, 0, 1, ex(2, 0, 0, 1, 2'b11)));
        foreach (rows[i]) begin
            raw_valid = rows[i].v; raw_phase = rows[i].p; fault_clear = rows[i].clr; en = rows[i].e;
            sb_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front(); got = obs(); n_cmp++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL invalid_loss[%0d]: got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_async_reset_and_enable();
        row_t rows[$];
        logic [7:0] got, exp_v;
        do_reset(); acquire(3'd5);
        drive(1'b1, 3'd6, 1'b0, 1'b1);
        drive(1'b1, 3'd6, 1'b0, 1'b1);
        n_cmp++;
        if (obs() !== ex(5, 0, 0, 0, 0)) begin
            n_err++; $display("FAIL mid_qual: got %b expected %b", obs(), ex(5, 0, 0, 0, 0));
        end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 8'h00) begin
            n_err++; $display("FAIL async_reset: got %b expected %b", obs(), 8'h00);
        end
        #2 reset_n = 1'b1;
        rows.push_back(r(1, 3'd3, 0, 1, ex(0, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd3, 0, 1, ex(0, 0, 0, 0, 0)));
        for (int i = 0; i < 5; i++) rows.push_back(r(1, 3'd3, 0, 0, ex(0, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd3, 0, 1, ex(0, 0, 0, 0, 0)));
        rows.push_back(r(1, 3'd3, 0, 1, ex(3, 1, 1, 0, 0)));
        rows.push_back(r(1, 3'd3, 0, 0, ex(3, 1, 0, 0, 0)));
        foreach (rows[i]) begin
            raw_valid = rows[i].v; raw_phase = rows[i].p; fault_clear = rows[i].clr; en = rows[i].e;
            sb_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front(); got = obs(); n_cmp++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL enable[%0d]: got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_illegal_fault();
        test_illegal_pairs();
        test_back_to_back();
        test_invalid_and_loss();
        test_async_reset_and_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
